// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding load/store at a time, serviced from a word array
// after a fixed latency, answered over a valid/ready response channel with an error flag.
// LATENCY must lie in 1..15 (the wait counter is 4 bits wide).
module dmem_responder #(
   parameter int unsigned DEPTH_WORDS = 256,
   parameter int unsigned LATENCY     = 2
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_write_i,
   input  logic [31:0] req_addr_i,
   input  logic [31:0] req_wdata_i,
   output logic        resp_valid_o,
   input  logic        resp_ready_i,
   output logic [31:0] resp_rdata_o,
   output logic        resp_err_o
);

   localparam int unsigned IdxW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

   typedef enum logic [1:0] {
      StIdle,
      StWait,
      StResp
   } state_e;

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        write_q, write_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;

   logic            access;
   logic            acc_err;
   logic [IdxW-1:0] idx;

   // Contents are deliberately not reset; power-up values are undefined.
   logic [31:0] mem [DEPTH_WORDS];

   // Decode the captured request: the access fires on the last WAIT cycle.
   always_comb begin
      access  = (state_q == StWait) && (cnt_q == 4'd0);
      acc_err = (addr_q[1:0] != 2'b00) || ({2'b00, addr_q[31:2]} >= 32'(DEPTH_WORDS));
      idx     = addr_q[IdxW+1:2];
   end

   // Next-state, request capture and response data.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      write_d = write_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      unique case (state_q)
         StIdle: begin
            if (req_valid_i) begin
               write_d = req_write_i;
               addr_d  = req_addr_i;
               wdata_d = req_wdata_i;
               cnt_d   = 4'(LATENCY - 1);
               state_d = StWait;
            end
         end
         StWait: begin
            if (cnt_q == 4'd0) begin
               err_d   = acc_err;
               rdata_d = (acc_err || write_q) ? 32'd0 : mem[idx];
               state_d = StResp;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         StResp: begin
            if (resp_ready_i) begin
               // Clear the payload so a stale value never lingers behind a dropped valid.
               rdata_d = 32'd0;
               err_d   = 1'b0;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Control and response registers; reset drops any in-flight request.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= StIdle;
         cnt_q   <= 4'd0;
         write_q <= 1'b0;
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
         rdata_q <= 32'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         write_q <= write_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // Store commit: only on the WAIT->RESP edge, whole word, never for faulting requests.
   // Reset forces state_q to StIdle, so a store cut short by reset never reaches here.
   always_ff @(posedge clk_i) begin
      if (access && write_q && !acc_err) begin
         mem[idx] <= wdata_q;
      end
   end

   // Handshake outputs decode straight from the state register.
   always_comb begin
      req_ready_o  = (state_q == StIdle);
      resp_valid_o = (state_q == StResp);
      resp_rdata_o = rdata_q;
      resp_err_o   = err_q;
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder at LATENCY 1, 2 and 15: each lane has its own DUT,
// driver, reference memory and response monitor.
module tb_dmem_responder;

   localparam int unsigned DEPTH = 256;
   localparam int unsigned NBLK  = 3;

   logic   clk = 1'b0;
   longint cyc = 0;
   int     n_checks = 0;
   int     n_fail = 0;
   bit     done [NBLK];

   always #5 clk = ~clk;

   // Rising edges seen so far; edge numbers are compared at negedges.
   always @(posedge clk) cyc++;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      bit          chk_data;
      longint      due;
   } exp_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
      end
   endtask

   for (genvar g = 0; g < NBLK; g++) begin : g_lat
      localparam int unsigned LAT = (g == 0) ? 1 : ((g == 1) ? 2 : 15);

      logic        rst = 1'b0;
      logic        req_valid, req_ready, req_write;
      logic [31:0] req_addr, req_wdata;
      logic        resp_valid, resp_err;
      logic        resp_ready = 1'b1;
      logic [31:0] resp_rdata;

      exp_t        q[$];
      logic [31:0] mm [int];
      longint      hs_edge = -10;
      bit          mode_rand = 0;
      bit          in_resp = 0;
      exp_t        cur;
      int          stall = 0;

      dmem_responder #(
         .DEPTH_WORDS(DEPTH),
         .LATENCY    (LAT)
      ) u_dut (
         .clk_i       (clk),
         .rst_i       (rst),
         .req_valid_i (req_valid),
         .req_ready_o (req_ready),
         .req_write_i (req_write),
         .req_addr_i  (req_addr),
         .req_wdata_i (req_wdata),
         .resp_valid_o(resp_valid),
         .resp_ready_i(resp_ready),
         .resp_rdata_o(resp_rdata),
         .resp_err_o  (resp_err)
      );

      // Monitor: pop on each new response, check it every cycle it is held, then apply backpressure.
      always @(negedge clk) begin
         if (!rst) begin
            in_resp    = 0;
            resp_ready = 1'b1;
         end else if (resp_valid) begin
            if (!in_resp) begin
               if (q.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL L%0d unexpected response: got valid, want none", LAT);
                  cur.rdata = 32'd0; cur.err = 1'b0; cur.chk_data = 0; cur.due = cyc;
               end else begin
                  cur = q.pop_front();
               end
               in_resp = 1;
               chk($sformatf("L%0d latency edge", LAT), 32'(cyc), 32'(cur.due));
               stall = mode_rand ? int'($urandom_range(0, 6)) : 0;
            end
            if (cur.chk_data) chk($sformatf("L%0d rdata", LAT), resp_rdata, cur.rdata);
            chk($sformatf("L%0d err", LAT), {31'd0, resp_err}, {31'd0, cur.err});
            chk($sformatf("L%0d req_ready in RESP", LAT), {31'd0, req_ready}, 32'd0);
            if (stall == 0) begin
               resp_ready = 1'b1;
               hs_edge    = cyc + 1;
               in_resp    = 0;
            end else begin
               resp_ready = 1'b0;
               stall--;
            end
         end else begin
            resp_ready = mode_rand ? 1'($urandom_range(0, 1)) : 1'b1;
         end
      end

      task automatic chk_reset_outputs(input string tag);
         chk($sformatf("L%0d %s req_ready", LAT, tag), {31'd0, req_ready}, 32'd1);
         chk($sformatf("L%0d %s resp_valid", LAT, tag), {31'd0, resp_valid}, 32'd0);
         chk($sformatf("L%0d %s resp_rdata", LAT, tag), resp_rdata, 32'd0);
         chk($sformatf("L%0d %s resp_err", LAT, tag), {31'd0, resp_err}, 32'd0);
      endtask

      // Issue one request from a negedge; returns at the negedge after acceptance with the
      // request still driven, so a following call keeps req_valid high across WAIT/RESP.
      task automatic do_req(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                            input bit b2b, input bit kill);
         int     n = 0;
         longint acc;
         exp_t   e;
         bit     er;
         req_valid = 1'b1;
         req_write = wr;
         req_addr  = a;
         req_wdata = wd;
         while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
         end
         if (!req_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL L%0d req_ready timeout: got 0, want 1", LAT);
            req_valid = 1'b0;
            return;
         end
         acc = cyc + 1;
         if (b2b) chk($sformatf("L%0d accept after handshake", LAT), 32'(acc - hs_edge), 32'd1);
         er = (a[1:0] != 2'b00) || (a >= 32'(4 * DEPTH));
         @(posedge clk);
         if (kill) begin
            @(negedge clk);
            rst       = 1'b0;
            req_valid = 1'b0;
            #1;
            chk_reset_outputs("mid-WAIT reset");
            repeat (2) @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            return;
         end
         e.err      = er;
         e.chk_data = er || wr || mm.exists(int'(a[31:2]));
         e.rdata    = (er || wr) ? 32'd0 : (e.chk_data ? mm[int'(a[31:2])] : 32'd0);
         e.due      = acc + LAT;
         q.push_back(e);
         if (!er && wr) mm[int'(a[31:2])] = wd;
         @(negedge clk);
      endtask

      initial begin
         int          n;
         bit          b2b;
         logic        wr;
         logic [31:0] a;
         int unsigned r;
         req_valid = 1'b0;
         req_write = 1'b0;
         req_addr  = 32'd0;
         req_wdata = 32'd0;
         repeat (3) @(negedge clk);
         chk_reset_outputs("power-on reset");
         rst = 1'b1;
         @(negedge clk);

         // Reset during WAIT must drop the store.
         do_req(1'b1, 32'h10, 32'h0, 0, 0);
         do_req(1'b1, 32'h10, 32'hDEADBEEF, 1, 1);
         do_req(1'b0, 32'h10, 32'h0, 0, 0);
         // Directed store/load, errors and top-of-array boundary, responses taken at once.
         do_req(1'b1, 32'h0, 32'h55AA0001, 1, 0);
         do_req(1'b1, 32'h40, 32'h12345678, 1, 0);
         do_req(1'b0, 32'h40, 32'hFFFFFFFF, 1, 0);
         do_req(1'b0, 32'h42, 32'h0, 1, 0);
         do_req(1'b1, 32'h400, 32'hFFFFFFFF, 1, 0);
         do_req(1'b0, 32'h0, 32'h0, 1, 0);
         do_req(1'b1, 32'h3FC, 32'hCAFEF00D, 1, 0);
         do_req(1'b0, 32'h3FC, 32'h0, 1, 0);
         do_req(1'b0, 32'h400, 32'h0, 1, 0);

         // Random traffic with random backpressure and idle gaps.
         mode_rand = 1;
         for (int i = 0; i < 80; i++) begin
            b2b = 1;
            if ($urandom_range(0, 3) == 0) begin
               req_valid = 1'b0;
               req_write = 1'($urandom_range(0, 1));
               req_addr  = $urandom;
               req_wdata = $urandom;
               repeat ($urandom_range(1, 4)) @(negedge clk);
               b2b = 0;
            end
            r = $urandom_range(0, 9);
            if (r < 6) begin
               n = int'($urandom_range(0, 7));
               a = (n == 7) ? 32'h3FC : 32'(n * 4);
            end else if (r < 8) begin
               a = {22'd0, 8'($urandom_range(0, 255)), 2'($urandom_range(1, 3))};
            end else if (r == 8) begin
               a = 32'h400 + ($urandom & 32'h0000_0FFC);
            end else begin
               a = $urandom | 32'h8000_0000;
               a[1:0] = 2'b00;
            end
            wr = 1'($urandom_range(0, 1));
            do_req(wr, a, $urandom, b2b, 0);
         end
         req_valid = 1'b0;

         n = 0;
         while ((q.size() != 0 || in_resp) && n < 200) begin
            @(negedge clk);
            n++;
         end
         if (q.size() != 0 || in_resp) begin
            n_checks++;
            n_fail++;
            $display("FAIL L%0d drain: got %0d outstanding, want 0", LAT, q.size());
         end
         done[g] = 1;
      end
   end

   initial begin
      fork
         wait (done[0] && done[1] && done[2]);
         begin
            #500000;
            n_fail++;
            $display("FAIL watchdog: got timeout, want all lanes done");
         end
      join_any
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Responder end of the pipeline's data-memory port: accepts one load/store request at a time from the MEM stage over a valid/ready handshake, services it from a word-organised array after a fixed programmable latency, and returns read data plus an error flag over a valid/ready response channel. It sits between the EX/MEM pipeline buffer and the MEM/WB buffer and lets the CPU be built against a multi-cycle memory rather than a combinational one.

## Interface
- DEPTH_WORDS, 256: number of 32-bit words stored; legal byte addresses 0 .. 4*DEPTH_WORDS-4.
- LATENCY, 2: cycles from request acceptance to response valid; legal range 1..15.
- clk_i  input  1  clock; all state changes on rising edge.
- rst_i  input  1  reset, asynchronous, active-low.
- req_valid_i  input  1  request present.
- req_ready_o  output  1  responder can accept a request this cycle.
- req_write_i  input  1  1 = store, 0 = load.
- req_addr_i  input  32  byte address.
- req_wdata_i  input  32  store data.
- resp_valid_o  output  1  response present.
- resp_ready_i  input  1  requester takes the response this cycle.
- resp_rdata_o  output  32  load data; 0 for stores and errors.
- resp_err_o  output  1  request was misaligned or out of range.

## Operation
- States: IDLE, WAIT, RESP.
- IDLE: req_ready_o=1. On req_valid_i&&req_ready_o, capture write, addr, wdata into request registers; load counter with LATENCY-1; go WAIT.
- WAIT: req_ready_o=0. If counter==0: perform access, go RESP; else counter decrements.
- Access (on the WAIT->RESP edge): err = (addr[1:0]!=0) || (addr[31:2] >= DEPTH_WORDS). If err: no array change, rdata=0, resp_err_o=1. Else store writes wdata to word addr[31:2], rdata=0; load sets rdata to word addr[31:2]; resp_err_o=0.
- RESP: resp_valid_o=1; resp_rdata_o/resp_err_o held stable until handshake. On resp_valid_o&&resp_ready_i go IDLE, resp_valid_o=0.
- Request-side inputs are ignored outside IDLE; a request held through WAIT/RESP is accepted only after returning to IDLE.
- Only the word at the requested index is modified by a store; no byte enables, no partial writes.
- Array contents are not affected by reset and are undefined at power-up.

## Timing
- Reset (rst_i=0, any time, including mid-request): state=IDLE, req_ready_o=1, resp_valid_o=0, resp_rdata_o=0, resp_err_o=0, counter=0, request registers=0. In-flight request is dropped; a store not yet at the WAIT->RESP edge does not modify the array.
- Acceptance at edge E0 -> resp_valid_o high from edge E(LATENCY) onward.
- Response handshake at edge Eh -> req_ready_o high from Eh; next acceptance earliest at Eh+1.
- With resp_ready_i tied high: one request per LATENCY+2 cycles.
- Load after store to the same word returns the stored value (store commits before the next request can be accepted).
- Outputs are registered; no combinational path from any input to any output.

## Test plan
- Reset: hold rst_i=0 mid-WAIT after a store of 0xDEADBEEF to 0x10 -> outputs at reset values immediately; later load 0x10 does not return 0xDEADBEEF (array preloaded with 0x0 via store first).
- Store/load, LATENCY=2, resp_ready_i=1: store 0x12345678 to 0x40, then load 0x40 -> resp_valid_o rises exactly 2 edges after each acceptance; load resp_rdata_o=0x12345678, resp_err_o=0; store resp_rdata_o=0.
- Backpressure: load with resp_ready_i=0 for 5 cycles -> resp_valid_o, resp_rdata_o stable for 5 cycles, req_ready_o=0 throughout; new req_valid_i ignored until one cycle after handshake.
- Errors: load 0x42 and store 0x400 (DEPTH_WORDS=256) -> resp_err_o=1, resp_rdata_o=0; subsequent load 0x0 unchanged by the faulting store.
- Latency sweep: LATENCY=1 and LATENCY=15 -> response at E1 / E15; throughput 3 / 17 cycles per request.
- Boundary: store 0xCAFEF00D to 0x3FC, load 0x3FC -> 0xCAFEF00D, resp_err_o=0; load 0x400 -> resp_err_o=1.
